// File: rtl/pointwise_conv_pkg.sv
// Shared definitions for the pointwise convolution engine.
//   - pw_state_t   : engine FSM states
//   - acc_width()  : accumulator width for a given activation width / fan-in
//   - sat_unsigned : clamp to [0, 2^bits-1]
//   - sat_signed   : clamp to [-2^(bits-1), 2^(bits-1)-1]
//   - PW_SLICE     : packed-vector slice for element idx of width w
`ifndef PW_SLICE
`define PW_SLICE(idx, w) [(idx)*(w) +: (w)]
`endif

package pointwise_conv_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} pw_state_t;

  // Working width for the saturation helpers; any accumulator fits in it.
  localparam int SAT_W = 64;

  // Product (2*BITS+1) plus growth for CH_IN terms plus one bit for the bias.
  function automatic int acc_width(input int bits, input int ch_in);
    return 2 * bits + 1 + $clog2(ch_in) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_unsigned(
      input logic signed [SAT_W-1:0] s, input int bits);
    logic signed [SAT_W-1:0] hi;
    hi = (64'sd1 <<< bits) - 64'sd1;
    if (s < 64'sd0) return 64'sd0;
    if (s > hi)     return hi;
    return s;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_signed(
      input logic signed [SAT_W-1:0] s, input int bits);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (s < lo) return lo;
    if (s > hi) return hi;
    return s;
  endfunction

endpackage

// File: rtl/pointwise_conv_engine_lane.sv
// pw_mac_lane: one MAC lane of the pointwise convolution engine.
// Multiplies an unsigned activation by a signed weight, accumulates on top of
// the channel bias (loaded when first=1), and presents the requantised,
// saturated value of (accumulator + current product) on res combinationally,
// so the parent can capture it on the edge that consumes the last product.
// Ports: clk_in, rst, x (activation), w (weight), bias, en (accumulate),
//        first (start a new channel), relu (saturation mode), res (result).
module pw_mac_lane
  import pointwise_conv_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int ACC_W = 38,
  parameter int SHIFT = 8
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [BITS-1:0]        x,
  input  logic signed [BITS-1:0] w,
  input  logic signed [2*BITS-1:0] bias,
  input  logic                   en,
  input  logic                   first,
  input  logic                   relu,
  output logic [BITS-1:0]        res
);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [SAT_W-1:0] s_wide;

  // Activation is unsigned: prepend a zero so it stays positive when signed.
  assign x_ext   = ACC_W'($signed({1'b0, x}));
  assign w_ext   = ACC_W'(w);
  assign prod    = x_ext * w_ext;
  assign sum     = (first ? ACC_W'(bias) : acc_reg) + prod;
  assign shifted = sum >>> SHIFT;
  assign s_wide  = SAT_W'(shifted);
  assign res     = relu ? BITS'(sat_unsigned(s_wide, BITS))
                        : BITS'(sat_signed(s_wide, BITS));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/pointwise_conv_engine.sv
// pointwise_conv_engine: time-multiplexed 1x1 convolution layer.
// One pixel (CH_IN unsigned activations) is accepted in IDLE, then PAR_OUT
// lanes walk G = CH_OUT/PAR_OUT output groups, one input channel per cycle.
// The full CH_OUT-channel result is held in OUT until downstream accepts.
// Ports: clk_in, rst (sync, active-high); data_in/in_valid/in_ready (pixel in);
//        data_out/out_valid/out_ready (result out); relu_en (saturation mode,
//        captured with the pixel); w_we/w_addr/w_data and b_we/b_addr/b_data
//        (weight and bias loading, IDLE only); busy; cfg_err (dropped write).
module pointwise_conv_engine
  import pointwise_conv_pkg::*;
#(
  parameter int BITS    = 16,
  parameter int CH_IN   = 16,
  parameter int CH_OUT  = 32,
  parameter int PAR_OUT = 8,
  parameter int SHIFT   = 8
) (
  input  logic                              clk_in,
  input  logic                              rst,
  input  logic [CH_IN*BITS-1:0]             data_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [CH_OUT*BITS-1:0]            data_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  input  logic                              relu_en,
  input  logic                              w_we,
  input  logic [$clog2(CH_IN*CH_OUT)-1:0]   w_addr,
  input  logic [BITS-1:0]                   w_data,
  input  logic                              b_we,
  input  logic [$clog2(CH_OUT)-1:0]         b_addr,
  input  logic [2*BITS-1:0]                 b_data,
  output logic                              busy,
  output logic                              cfg_err
);

  localparam int G     = CH_OUT / PAR_OUT;
  localparam int ACC_W = acc_width(BITS, CH_IN);
  localparam int WA_W  = $clog2(CH_IN * CH_OUT);
  localparam int BA_W  = $clog2(CH_OUT);
  localparam int G_W   = (G > 1) ? $clog2(G) : 1;
  localparam int C_W   = $clog2(CH_IN);

  logic signed [BITS-1:0]   w_mem [CH_IN*CH_OUT];
  logic signed [2*BITS-1:0] b_mem [CH_OUT];

  pw_state_t               state_reg;
  logic [G_W-1:0]          g_reg;
  logic [C_W-1:0]          c_reg;
  logic [CH_IN*BITS-1:0]   x_reg;
  logic                    relu_reg;
  logic [CH_OUT*BITS-1:0]  data_out_reg;
  logic                    out_valid_reg;
  logic                    busy_reg;
  logic                    cfg_err_reg;

  logic                    accept;
  logic                    mac_en;
  logic                    mac_first;
  logic                    mac_last;
  logic [BITS-1:0]         x_cur;
  logic [BITS-1:0]         lane_res [PAR_OUT];

  // Held low during reset so nothing is accepted on the reset edge.
  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign mac_en    = (state_reg == ST_MAC);
  assign mac_first = (c_reg == '0);
  assign mac_last  = (c_reg == C_W'(CH_IN - 1));
  assign x_cur     = x_reg `PW_SLICE(c_reg, BITS);

  assign data_out  = data_out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign cfg_err   = cfg_err_reg;

  // Coefficient memories: not reset, writable only while idle. A write in the
  // accept cycle lands before the first MAC read, so that pixel sees it.
  always_ff @(posedge clk_in) begin
    if (w_we && state_reg == ST_IDLE) w_mem[w_addr] <= w_data;
    if (b_we && state_reg == ST_IDLE) b_mem[b_addr] <= b_data;
  end

  for (genvar gi = 0; gi < PAR_OUT; gi++) begin : g_lane
    logic [WA_W-1:0] w_idx;
    logic [BA_W-1:0] b_idx;

    assign b_idx = BA_W'(int'(g_reg) * PAR_OUT + gi);
    assign w_idx = WA_W'((int'(g_reg) * PAR_OUT + gi) * CH_IN + int'(c_reg));

    pw_mac_lane #(
      .BITS  (BITS),
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk_in (clk_in),
      .rst    (rst),
      .x      (x_cur),
      .w      (w_mem[w_idx]),
      .bias   (b_mem[b_idx]),
      .en     (mac_en),
      .first  (mac_first),
      .relu   (relu_reg),
      .res    (lane_res[gi])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      g_reg         <= '0;
      c_reg         <= '0;
      x_reg         <= '0;
      relu_reg      <= 1'b0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= (w_we || b_we) && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            x_reg     <= data_in;
            relu_reg  <= relu_en;
            g_reg     <= '0;
            c_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (mac_last) begin
            // Lane outputs already include the final product.
            for (int p = 0; p < PAR_OUT; p++) begin
              data_out_reg `PW_SLICE(int'(g_reg) * PAR_OUT + p, BITS) <= lane_res[p];
            end
            c_reg <= '0;
            if (g_reg == G_W'(G - 1)) begin
              g_reg         <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_OUT;
            end else begin
              g_reg <= g_reg + 1'b1;
            end
          end else begin
            c_reg <= c_reg + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
